serial_deser: RTL and testbench
===============================

# serial_deser

Parametrised serial-to-parallel deserializer and the successor to the team's fixed 7-bit serial-to-ASCII shifter. It assembles WIDTH-bit words from a qualified serial bit stream, in either bit order, and presents each completed word on a held output register under a valid/ack handshake with sticky overrun detection. It sits between a serial front end (UART/line decoder) and byte- or character-oriented consumers. Optional parity checking is compiled in by macro.

## Interface
- WIDTH, 7, data bits per word (≥2)
- MSB_FIRST, 1, 1: first received bit lands in out[WIDTH-1]; 0: first received bit lands in out[0]
- CW, $clog2(WIDTH+2), width of bit_cnt (derived; do not override)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in  in  1  serial data bit
- in_en  in  1  bit qualifier; in is accepted on a clk edge only when in_en=1
- clear  in  1  abandon partial frame
- ack  in  1  consumer accepts r_out
- out  out  WIDTH  live shift register (partial word)
- r_out  out  WIDTH  last completed word, held
- on  out  1  r_out valid
- overrun  out  1  sticky: a completed word overwrote an unacknowledged one
- bit_cnt  out  CW  bits accepted in current frame
- par_err  out  1  parity error for the word in r_out (0 unless parity is compiled in)

## Operation
- Frame length L = WIDTH, or WIDTH+1 with parity; bit_cnt runs 0..L-1, then wraps to 0.
- Data bit accepted (in_en=1, bit_cnt<WIDTH): MSB_FIRST=1 → out <= {out[WIDTH-2:0], in}; MSB_FIRST=0 → out <= {in, out[WIDTH-1:1]}; bit_cnt++.
- Parity bit (bit_cnt==WIDTH, parity build only): not shifted into out.
- Final bit accepted (bit_cnt==L-1): r_out <= completed word (including this bit when it is a data bit); on <= 1; bit_cnt <= 0. out keeps the completed word until the next accepted bit.
- Handshake: ack is effective only on an edge where on=1, and then on <= 0. ack with on=0 is ignored. r_out is stable while on=1, except on overrun.
- Completion and effective ack on the same edge: the new word loads, on stays 1, overrun is unchanged.
- Completion with on=1 and no ack: r_out is overwritten, on stays 1, overrun <= 1. overrun clears only on rst.
- clear: out <= 0 and bit_cnt <= 0. It does not affect r_out, on, overrun or par_err. When clear and in_en are both high, clear wins and the bit is discarded.
- Priority: rst > clear > bit acceptance; ack is evaluated independently.

## Timing
- Reset value: all outputs are 0 (out, r_out, on, overrun, bit_cnt, par_err).
- Registered outputs only; no combinational path from any input to any output.
- Latency: r_out, on and par_err update on the same edge that accepts the final bit, so they are visible in the following cycle.
- Throughput: one bit per cycle. Back-to-back frames need no idle cycles.
- rst mid-frame: the partial word is discarded and every output returns to 0 on that edge.

## Configuration
- SERIAL_DESER_PARITY_EN defined:
  - L = WIDTH+1 and an even-parity bit follows the data bits.
  - par_err <= XOR(data bits, parity bit), loaded with r_out.
  - A word with a parity error is still delivered with on=1.
- Macro undefined:
  - L = WIDTH.
  - par_err is tied to 0.
  - No parity logic is generated.

## Test plan
- WIDTH=7, MSB_FIRST=1, in_en=1, bits 1,0,1,1,0,0,1 → after the 7th edge: r_out=7'h59, on=1, bit_cnt=0, overrun=0.
- MSB_FIRST=0, same bits → r_out=7'h4D.
- Same 7 bits with in_en low for 2 cycles between bits → bit_cnt holds during gaps and r_out=7'h59. Assert clear after 3 bits, then send 7 new bits → r_out equals only the new 7 bits.
- Send word 7'h59, no ack, then word 7'h2A → r_out=7'h2A, on=1, overrun=1. Repeat from rst with ack on the completion edge of word 2 → on=1, overrun=0. rst asserted after 4 bits → all outputs 0 on the next cycle.
- SERIAL_DESER_PARITY_EN, WIDTH=7: data 7'h59 (four ones) followed by parity bit 0 → par_err=0. Parity bit 1 → par_err=1, r_out=7'h59, on=1.

Source files
------------

// File: rtl/serial_deser_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_deser_if
// Purpose  : Bundles the serial input, the handshake and the status outputs
//            of serial_deser.
//            The slave modport is the deserializer. The master modport is its
//            environment, meaning the serial front end plus the word consumer.
// Signals  : in, in_en, clear, ack              (master -> slave)
//            out, r_out, on, overrun, bit_cnt,  (slave -> master)
//            par_err
// Revision : 1.0  initial release
// ============================================================================
interface serial_deser_if #(
  parameter int WIDTH = 7,
  parameter int CW    = $clog2(WIDTH + 2)
);
  logic             in;
  logic             in_en;
  logic             clear;
  logic             ack;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] r_out;
  logic             on;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;
  logic             par_err;

  modport slave (
    input  in, in_en, clear, ack,
    output out, r_out, on, overrun, bit_cnt, par_err
  );

  modport master (
    output in, in_en, clear, ack,
    input  out, r_out, on, overrun, bit_cnt, par_err
  );
endinterface
`default_nettype wire

// File: rtl/serial_deser.sv
`default_nettype none
// ============================================================================
// Module   : serial_deser
// Purpose  : Parametrised serial-to-parallel deserializer. It assembles
//            WIDTH-bit words from a qualified bit stream in either bit order.
//            Each completed word is held in r_out under a valid/ack
//            handshake, with sticky overrun detection.
// Macro    : SERIAL_DESER_PARITY_EN
//            When defined, an even-parity bit follows the data bits of each
//            frame and is checked into par_err.
//            When undefined, par_err is tied to 0.
// Ports    : clk, rst (sync, active-high)
//            bus (serial_deser_if.slave):
//              in/in_en  qualified serial bit
//              clear     abandon the partial frame
//              ack       consumer accepts r_out
//              out       live shift register
//              r_out     last completed word
//              on        r_out valid
//              overrun   sticky overwrite of an unacknowledged word
//              bit_cnt   bits accepted in the current frame
//              par_err   parity error for the word in r_out
// Revision : 1.0  initial release
// ============================================================================
module serial_deser #(
  parameter int WIDTH     = 7,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 2)
) (
  input  wire logic      clk,
  input  wire logic      rst,
  serial_deser_if.slave  bus
);

`ifdef SERIAL_DESER_PARITY_EN
  localparam int c_frame_len = WIDTH + 1;
`else
  localparam int c_frame_len = WIDTH;
`endif

  localparam logic [CW-1:0] c_width = CW'(WIDTH);
  localparam logic [CW-1:0] c_last  = CW'(c_frame_len - 1);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;
  logic             r_par_err;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_is_data;
  logic             w_last;
  logic             w_ack;

  // clear outranks bit acceptance, so a bit that arrives with clear is lost.
  assign w_accept  = bus.in_en && !bus.clear;
  assign w_is_data = (r_cnt < c_width);
  assign w_last    = w_accept && (r_cnt == c_last);
  assign w_ack     = bus.ack && r_valid;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_nxt = {r_shift[WIDTH-2:0], bus.in};
    end else begin : g_lsb_first
      assign w_shift_nxt = {bus.in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // When the final bit is the parity bit, the data word is already complete
  // in the shift register.
  assign w_word = w_is_data ? w_shift_nxt : r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.clear) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (bus.in_en) begin
        if (w_is_data) begin
          r_shift <= w_shift_nxt;
        end
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end

      // If a word completes on the same edge as an effective ack, the new
      // word replaces the acknowledged one and valid stays high.
      if (w_last) begin
        r_word  <= w_word;
        r_valid <= 1'b1;
        if (r_valid && !w_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (w_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  // On the final edge, bus.in carries the parity bit. XORing it with the
  // data bits gives 1 when the total number of ones is odd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_last) begin
      r_par_err <= (^r_shift) ^ bus.in;
    end
  end
`else
  assign r_par_err = 1'b0;
`endif

  assign bus.out     = r_shift;
  assign bus.r_out   = r_word;
  assign bus.on      = r_valid;
  assign bus.overrun = r_overrun;
  assign bus.bit_cnt = r_cnt;
  assign bus.par_err = r_par_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_deser
// Purpose  : Self-checking bench for serial_deser.
//            It runs two instances on the same inputs, one MSB-first and one
//            LSB-first, both with WIDTH=7.
//            The bench models the serial history as a queue of received bits
//            and derives every output from that queue. It covers the
//            directed scenarios and then a randomized stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_deser;
  localparam int W  = 7;
  localparam int CW = $clog2(W + 2);
`ifdef SERIAL_DESER_PARITY_EN
  localparam int L      = W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int L      = W;
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, din, in_en, clear, ack;

  always #5 clk = ~clk;

  serial_deser_if #(.WIDTH(W)) bus0 ();
  serial_deser_if #(.WIDTH(W)) bus1 ();

  assign bus0.in = din;  assign bus0.in_en = in_en;
  assign bus0.clear = clear;  assign bus0.ack = ack;
  assign bus1.in = din;  assign bus1.in_en = in_en;
  assign bus1.clear = clear;  assign bus1.ack = ack;

  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit             hist[$];   // data bits since the last reset or clear, newest last
  int             m_cnt;
  logic [W-1:0]   m_rout0, m_rout1;
  bit             m_on, m_ovr, m_par;

  // Newest bit sits at bit 0 for MSB-first and at bit W-1 for LSB-first.
  function automatic logic [W-1:0] hist_word(input bit msb);
    logic [W-1:0] w = '0;
    for (int k = 0; k < hist.size(); k++) begin
      if (msb) w[k] = hist[hist.size() - 1 - k];
      else     w[W - 1 - k] = hist[hist.size() - 1 - k];
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt = 0; m_rout0 = '0; m_rout1 = '0;
    m_on = 0; m_ovr = 0; m_par = 0;
  endtask

  task automatic model_update();
    bit ack_eff, done, pbit;
    int ones;
    if (rst) begin
      model_reset();
      return;
    end
    ack_eff = ack && m_on;
    done = 0; pbit = 0;
    if (clear) begin
      hist.delete();
      m_cnt = 0;
    end else if (in_en) begin
      if (m_cnt < W) begin
        hist.push_back(din);
        if (hist.size() > W) void'(hist.pop_front());
      end else begin
        pbit = din;
      end
      m_cnt++;
      if (m_cnt == L) begin
        m_cnt = 0;
        done  = 1;
      end
    end
    if (done) begin
      if (m_on && !ack_eff) m_ovr = 1;
      m_rout0 = hist_word(1'b1);
      m_rout1 = hist_word(1'b0);
      m_on = 1;
      ones = int'(pbit);
      foreach (hist[i]) ones += int'(hist[i]);
      m_par = PAR_EN && (ones % 2 == 1);
    end else if (ack_eff) begin
      m_on = 0;
    end
  endtask

  task automatic compare_all();
    chk("d0.out",     32'(bus0.out),     32'(hist_word(1'b1)));
    chk("d0.r_out",   32'(bus0.r_out),   32'(m_rout0));
    chk("d0.on",      32'(bus0.on),      32'(m_on));
    chk("d0.overrun", 32'(bus0.overrun), 32'(m_ovr));
    chk("d0.bit_cnt", 32'(bus0.bit_cnt), 32'(m_cnt));
    chk("d0.par_err", 32'(bus0.par_err), 32'(m_par));
    chk("d1.out",     32'(bus1.out),     32'(hist_word(1'b0)));
    chk("d1.r_out",   32'(bus1.r_out),   32'(m_rout1));
    chk("d1.on",      32'(bus1.on),      32'(m_on));
    chk("d1.overrun", 32'(bus1.overrun), 32'(m_ovr));
    chk("d1.bit_cnt", 32'(bus1.bit_cnt), 32'(m_cnt));
    chk("d1.par_err", 32'(bus1.par_err), 32'(m_par));
  endtask

  // Inputs change only after the falling edge. The model samples them on
  // the rising edge, and outputs are compared on the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // Sends w[W-1] first. In a parity build a parity bit pb follows the data.
  // ack_last raises ack on the edge that completes the frame.
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit pb, input bit ack_last);
    for (int i = W - 1; i >= 0; i--) begin
      din = w[i]; in_en = 1'b1;
      ack = (i == 0 && !PAR_EN) ? ack_last : 1'b0;
      tick();
      ack = 1'b0;
      if (gap > 0 && i > 0) begin
        in_en = 1'b0;
        repeat (gap) tick();
      end
    end
    if (PAR_EN) begin
      din = pb; in_en = 1'b1; ack = ack_last;
      tick();
      ack = 1'b0;
    end
    in_en = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; in_en = 1'b0; clear = 1'b0; ack = 1'b0;
    model_reset();
    do_reset();
    chk("rst.r_out", 32'(bus0.r_out), 32'h0);
    chk("rst.on", 32'(bus0.on), 32'h0);

    // Basic word in both bit orders.
    send_word(7'b1011001, 0, 1'b0, 1'b0);
    chk("tp.msb_rout", 32'(bus0.r_out), 32'h59);
    chk("tp.lsb_rout", 32'(bus1.r_out), 32'h4D);
    chk("tp.on", 32'(bus0.on), 32'h1);
    chk("tp.bit_cnt", 32'(bus0.bit_cnt), 32'h0);
    chk("tp.overrun", 32'(bus0.overrun), 32'h0);
    pulse_ack();
    chk("tp.ack_on", 32'(bus0.on), 32'h0);

    // Same word with two idle cycles between bits.
    send_word(7'b1011001, 2, 1'b0, 1'b0);
    chk("tp.gap_rout", 32'(bus0.r_out), 32'h59);
    pulse_ack();

    // Partial frame abandoned by clear, with in_en high alongside clear.
    in_en = 1'b1;
    din = 1'b1; tick(); din = 1'b1; tick(); din = 1'b1; tick();
    clear = 1'b1; tick(); clear = 1'b0; in_en = 1'b0;
    chk("tp.clr_cnt", 32'(bus0.bit_cnt), 32'h0);
    send_word(7'h2A, 0, 1'b1, 1'b0);
    chk("tp.clr_rout", 32'(bus0.r_out), 32'h2A);
    pulse_ack();

    // Overrun: a second word arrives without an ack.
    send_word(7'h59, 0, 1'b0, 1'b0);
    send_word(7'h2A, 0, 1'b1, 1'b0);
    chk("tp.ovr_rout", 32'(bus0.r_out), 32'h2A);
    chk("tp.ovr_on", 32'(bus0.on), 32'h1);
    chk("tp.ovr_flag", 32'(bus0.overrun), 32'h1);

    // An ack on the completion edge prevents the overrun.
    do_reset();
    send_word(7'h59, 0, 1'b0, 1'b0);
    send_word(7'h2A, 0, 1'b1, 1'b1);
    chk("tp.ackc_on", 32'(bus0.on), 32'h1);
    chk("tp.ackc_ovr", 32'(bus0.overrun), 32'h0);

    // Reset mid-frame.
    in_en = 1'b1;
    repeat (4) begin din = 1'b1; tick(); end
    in_en = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("tp.rst_out", 32'(bus0.out), 32'h0);
    chk("tp.rst_rout", 32'(bus0.r_out), 32'h0);
    chk("tp.rst_on", 32'(bus0.on), 32'h0);
    chk("tp.rst_cnt", 32'(bus0.bit_cnt), 32'h0);

`ifdef SERIAL_DESER_PARITY_EN
    send_word(7'h59, 0, 1'b0, 1'b0);
    chk("tp.par_ok", 32'(bus0.par_err), 32'h0);
    pulse_ack();
    send_word(7'h59, 0, 1'b1, 1'b0);
    chk("tp.par_bad", 32'(bus0.par_err), 32'h1);
    chk("tp.par_rout", 32'(bus0.r_out), 32'h59);
    chk("tp.par_on", 32'(bus0.on), 32'h1);
`endif

    // Randomized stream.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 399) == 0);
      clear = ($urandom_range(0, 39) == 0);
      in_en = ($urandom_range(0, 3) != 0);
      din   = $urandom_range(0, 1) != 0;
      ack   = ($urandom_range(0, 9) < 3);
      tick();
    end
    rst = 1'b0; clear = 1'b0; in_en = 1'b0; ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
